// File: rtl/aes_pkg.sv
// Shared AES SubBytes constants: state geometry, FSM encoding and the forward/inverse S-box tables.
// Pure declarations; no logic, no latency, no flow control.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sb_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sub_bytes_engine_if.sv
// start/done handshake bundle between the round-key adder side (master) and the SubBytes engine (slave).
// Wiring only; start is sampled by the engine in IDLE, no backpressure beyond busy.
interface aes_sub_bytes_engine_if;
    import aes_pkg::*;

    logic                   start;
    logic                   inv_mode;
    logic [AES_STATE_W-1:0] state_in;
    logic                   busy;
    logic                   done;
    logic [AES_STATE_W-1:0] state_out;

    modport master (output start, inv_mode, state_in, input busy, done, state_out);
    modport slave  (input start, inv_mode, state_in, output busy, done, state_out);
endinterface

// File: rtl/aes_sbox_lane.sv
// One byte-wide S-box lookup, forward or inverse selected by inv.
// Purely combinational, zero latency, no flow control.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    assign dout = inv ? INV_SBOX[din] : SBOX[din];

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state, NUM_SBOX bytes per cycle.
// done follows start by 16/NUM_SBOX+PIPE_SBOX+1 edges; start while busy is dropped, not queued.
module aes_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned NUM_SBOX   = 4,
    parameter int unsigned INVERSE_EN = 1,
    parameter int unsigned PIPE_SBOX  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_sub_bytes_engine_if.slave bus
);

    localparam int NS = int'(NUM_SBOX);
    localparam int N  = AES_BYTES / NS;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(N - 1);
    localparam logic INV_OK = (INVERSE_EN != 0);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("aes_sub_bytes_engine: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    sb_state_t              state_q, state_d;
    logic [GW-1:0]          grp_cnt_q, grp_cnt_d;
    logic                   mode_q, mode_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] out_q, out_d;
    logic [7:0]             pipe_q [NS];
    logic [7:0]             pipe_d [NS];
    logic [GW-1:0]          pipe_grp_q, pipe_grp_d;
    logic                   pipe_vld_q, pipe_vld_d;
    logic [7:0]             lane_in  [NS];
    logic [7:0]             lane_out [NS];

    for (genvar l = 0; l < NS; l++) begin : g_lane
        aes_sbox_lane u_lane (
            .din  (lane_in[l]),
            .inv  (mode_q),
            .dout (lane_out[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        grp_cnt_d  = grp_cnt_q;
        mode_d     = mode_q;
        work_d     = work_q;
        out_d      = out_q;
        pipe_d     = pipe_q;
        pipe_grp_d = pipe_grp_q;
        pipe_vld_d = 1'b0;

        for (int l = 0; l < NS; l++) begin
            lane_in[l] = work_q[(int'(grp_cnt_q) * NS + l) * 8 +: 8];
        end

        // With the pipe stage, each group lands in the working register one cycle after lookup.
        if (PIPE_SBOX != 0 && pipe_vld_q) begin
            for (int l = 0; l < NS; l++) begin
                work_d[(int'(pipe_grp_q) * NS + l) * 8 +: 8] = pipe_q[l];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d    = bus.state_in;
                    mode_d    = bus.inv_mode & INV_OK;
                    grp_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (PIPE_SBOX != 0) begin
                    pipe_vld_d = 1'b1;
                    pipe_grp_d = grp_cnt_q;
                    for (int l = 0; l < NS; l++) pipe_d[l] = lane_out[l];
                end else begin
                    for (int l = 0; l < NS; l++) begin
                        work_d[(int'(grp_cnt_q) * NS + l) * 8 +: 8] = lane_out[l];
                    end
                end
                if (grp_cnt_q == LAST_GRP) begin
                    state_d = (PIPE_SBOX != 0) ? DRAIN : DONE;
                end else begin
                    grp_cnt_d = grp_cnt_q + GW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result register is loaded on entry to DONE so state_out is valid alongside the done pulse.
        if (state_d == DONE && state_q != DONE) begin
            out_d = work_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grp_cnt_q  <= '0;
            mode_q     <= 1'b0;
            work_q     <= '0;
            out_q      <= '0;
            pipe_q     <= '{default: '0};
            pipe_grp_q <= '0;
            pipe_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_cnt_q  <= grp_cnt_d;
            mode_q     <= mode_d;
            work_q     <= work_d;
            out_q      <= out_d;
            pipe_q     <= pipe_d;
            pipe_grp_q <= pipe_grp_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.state_out = out_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed bench for aes_sub_bytes_engine across five parameter sets sharing one clock and reset.
// Latency is counted in rising edges, the start-sampling edge being edge 1.
module tb_aes_sub_bytes_engine;
    import aes_pkg::*;

    localparam int NDUT = 5;
    localparam int NS_P [NDUT] = '{4, 1, 16, 4, 4};
    localparam int IE_P [NDUT] = '{1, 1, 1,  1, 0};
    localparam int PS_P [NDUT] = '{0, 0, 0,  1, 0};

    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] V_IN   = 128'h00000000000000000000006174FF0043;
    localparam logic [127:0] V_OUT  = 128'h6363636363636363636363EF9216631A;
    localparam logic [127:0] V6_IN  = 128'h00000000000000000000000000000043;
    localparam logic [127:0] V6_OUT = {{15{8'h63}}, 8'h1A};

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] start_v;
    logic [NDUT-1:0] inv_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [127:0]    sin_a  [NDUT];
    logic [127:0]    sout_a [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        aes_sub_bytes_engine_if bus_if ();
        assign bus_if.start    = start_v[i];
        assign bus_if.inv_mode = inv_v[i];
        assign bus_if.state_in = sin_a[i];
        assign busy_v[i]       = bus_if.busy;
        assign done_v[i]       = bus_if.done;
        assign sout_a[i]       = bus_if.state_out;

        aes_sub_bytes_engine #(
            .NUM_SBOX   (NS_P[i]),
            .INVERSE_EN (IE_P[i]),
            .PIPE_SBOX  (PS_P[i])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: checks latency and the single-cycle done pulse, returns state_out seen with done.
    task automatic run_op(input int d, input logic mode, input logic [127:0] din,
                          input int exp_lat, input string tag, output logic [127:0] dout);
        int edges;
        edges = 0;
        @(negedge clk);
        start_v[d] = 1'b1;
        inv_v[d]   = mode;
        sin_a[d]   = din;
        do begin
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
            edges++;
        end while (!done_v[d] && edges < 100);
        dout = sout_a[d];
        chk({tag, "_lat"}, 128'(edges), 128'(exp_lat));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 128'(done_v[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] mid;
        logic [127:0] rnd;
        logic [127:0] got;
        int pulses;

        rst     = 1'b1;
        start_v = '0;
        inv_v   = '0;
        for (int i = 0; i < NDUT; i++) sin_a[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy_v[0]), 128'd0);
        chk("rst_done", 128'(done_v[0]), 128'd0);
        chk("rst_out",  sout_a[0], 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero state, four lanes, no pipe.
        run_op(0, 1'b0, 128'd0, 5, "t1_zero", res);
        chk("t1_zero_out", res, ALL63);
        chk("t1_hold_idle", sout_a[0], ALL63);

        // Same directed vector through every forward configuration.
        run_op(0, 1'b0, V_IN, 5,  "t2_ns4",   res); chk("t2_ns4_out",   res, V_OUT);
        run_op(1, 1'b0, V_IN, 17, "t2_ns1",   res); chk("t2_ns1_out",   res, V_OUT);
        run_op(2, 1'b0, V_IN, 2,  "t2_ns16",  res); chk("t2_ns16_out",  res, V_OUT);
        run_op(3, 1'b0, V_IN, 6,  "t2_pipe",  res); chk("t2_pipe_out",  res, V_OUT);

        run_op(0, 1'b1, V_OUT, 5, "t3_inv",      res); chk("t3_inv_out",      res, V_IN);
        run_op(3, 1'b1, V_OUT, 6, "t3_inv_pipe", res); chk("t3_inv_pipe_out", res, V_IN);

        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_op(0, 1'b0, rnd, 5, "t3_rt_fwd", mid);
        run_op(0, 1'b1, mid, 5, "t3_rt_inv", res);
        chk("t3_roundtrip", res, rnd);

        // A second start during RUN must be dropped.
        @(negedge clk);
        start_v[0] = 1'b1; inv_v[0] = 1'b0; sin_a[0] = 128'd0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; sin_a[0] = V_IN;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        pulses = 0;
        got    = '0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                pulses++;
                got = sout_a[0];
            end
        end
        chk("t4_done_count", 128'(pulses), 128'd1);
        chk("t4_first_only", got, ALL63);

        // Reset while group 2 is being processed.
        @(negedge clk);
        start_v[0] = 1'b1; sin_a[0] = V_IN;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy",     128'(busy_v[0]), 128'd0);
        chk("t5_done",     128'(done_v[0]), 128'd0);
        chk("t5_out",      sout_a[0], 128'd0);
        chk("t5_fsm_idle", 128'(g_dut[0].u_dut.state_q), 128'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done_v[0]) pulses++;
        end
        chk("t5_no_done", 128'(pulses), 128'd0);
        run_op(0, 1'b0, V_IN, 5, "t5_fresh", res);
        chk("t5_fresh_out", res, V_OUT);

        // inv_mode is ignored when the inverse table is not built.
        run_op(4, 1'b1, V6_IN, 5, "t6_noinv", res);
        chk("t6_noinv_out", res, V6_OUT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
